// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo block: output mode selectors and depth helper.
package sync_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Number of words addressed by an awidth-bit pointer.
    function automatic int unsigned fifo_depth(input int unsigned awidth);
        return 32'd1 << awidth;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
//   clr                 synchronous flush
//   wr_en / wr_data     write request and payload
//   rd_en               read request (standard) or pop (FWFT)
//   rd_data / rd_valid  read payload and its qualifier
//   full / empty        acceptance flags
//   almost_full/_empty  threshold flags
//   level               words held, 0..DEPTH
//   overflow/underflow  one-cycle rejected-request strobes
interface sync_fifo_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 6
);
    logic              clr;
    logic              wr_en;
    logic [DWIDTH-1:0] wr_data;
    logic              rd_en;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AWIDTH:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram_core.sv
// Single-clock dual-port RAM: one write port, one read port whose address is sampled
// at the clock edge and whose data lands in an output register.
//   clk, rst_n      clock / async reset (output register only, storage is not reset)
//   i_clr           synchronous clear of the output register
//   i_wr_en/_addr/_data   write port
//   i_rd_en/_addr   read port, o_rd_data valid after the sampling edge
module fifo_ram_core
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);
    localparam int unsigned DEPTH = fifo_depth(AWIDTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_q;

    // Storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read output register; resettable so the FIFO read data starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_rd_en) begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO over fifo_ram_core with standard or first-word-fall-through output,
// fill level, threshold flags and overflow/underflow strobes.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         sync_fifo_if slave modport (requests in, data/status out)
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned AWIDTH     = 6,
    parameter int unsigned FWFT       = FIFO_MODE_STD,
    parameter int unsigned AFULL_LVL  = fifo_depth(AWIDTH) - 4,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    sync_fifo_if.slave bus
);
    localparam int unsigned DEPTH = fifo_depth(AWIDTH);
    localparam int unsigned LW    = AWIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;

    logic [LW-1:0]     w_level_nxt;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ram_rd;
    logic              w_empty_nxt;
    logic [DWIDTH-1:0] w_ram_q;

    // Request acceptance and next fill level; flags are judged on the registered state,
    // so a read at full never makes room for a same-cycle write.
    always_comb begin
        w_wr_acc    = bus.wr_en && !r_full  && !bus.clr;
        w_rd_acc    = bus.rd_en && !r_empty && !bus.clr;
        w_level_nxt = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
    end

    // Pointers, level and registered flags; clr mirrors reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
            end
            r_level     <= w_level_nxt;
            r_full      <= (w_level_nxt == DEPTH_L);
            r_empty     <= w_empty_nxt;
            r_afull     <= (w_level_nxt >= AFULL_L);
            r_aempty    <= (w_level_nxt <= AEMPTY_L);
            r_overflow  <= bus.wr_en && r_full;
            r_underflow <= bus.rd_en && r_empty;
        end
    end

    fifo_ram_core #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (bus.clr),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Two-entry prefetch: RAM output register (q stage) feeding the output register.
            // ram_cnt counts committed words still in RAM, so a prefetch never targets the
            // word being written in the same cycle. Here empty means "no head word presented",
            // which lags level by the prefetch latency.
            logic [LW-1:0]     r_ram_cnt;
            logic [LW-1:0]     w_ram_cnt_nxt;
            logic              r_q_vld;
            logic              r_dout_vld;
            logic [DWIDTH-1:0] r_dout;
            logic              w_dout_free;
            logic              w_q_vld_nxt;
            logic              w_dout_vld_nxt;

            always_comb begin
                w_dout_free    = !r_dout_vld || w_rd_acc;
                w_ram_rd       = (r_ram_cnt != '0) && (!r_q_vld || w_dout_free) && !bus.clr;
                w_q_vld_nxt    = w_ram_rd || (r_q_vld && !w_dout_free);
                w_dout_vld_nxt = w_dout_free ? r_q_vld : 1'b1;
                w_ram_cnt_nxt  = r_ram_cnt + LW'(w_wr_acc) - LW'(w_ram_rd);
                w_empty_nxt    = !w_dout_vld_nxt;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ram_cnt  <= '0;
                    r_q_vld    <= 1'b0;
                    r_dout_vld <= 1'b0;
                    r_dout     <= '0;
                end else if (bus.clr) begin
                    r_ram_cnt  <= '0;
                    r_q_vld    <= 1'b0;
                    r_dout_vld <= 1'b0;
                    r_dout     <= '0;
                end else begin
                    r_ram_cnt  <= w_ram_cnt_nxt;
                    r_q_vld    <= w_q_vld_nxt;
                    r_dout_vld <= w_dout_vld_nxt;
                    if (w_dout_free && r_q_vld) begin
                        r_dout <= w_ram_q;
                    end
                end
            end

            assign bus.rd_data  = r_dout;
            assign bus.rd_valid = r_dout_vld;
        end else begin : g_std
            // Standard: accepted read goes straight to the RAM; its output register is rd_data.
            logic r_rd_valid;

            assign w_ram_rd    = w_rd_acc;
            assign w_empty_nxt = (w_level_nxt == '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_valid <= 1'b0;
                end else if (bus.clr) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                end
            end

            assign bus.rd_data  = w_ram_q;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.level        = r_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
